// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory from address 0.
// Optional trailing 8-bit payload checksum when IMEM_LOADER_CSUM_EN is defined.
module imem_loader #(
  parameter int ADDR_BITS = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic                 core_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR} state_t;
  localparam state_t S_END = S_CSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
  localparam state_t S_END = S_DONE;
`endif

  // Largest legal word count; compared at 33 bits so N up to 2**32-1 is judged correctly.
  localparam logic [32:0] MAX_N = 33'd1 << ADDR_BITS;

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [31:0]          word_q, word_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   n_q, n_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  logic [31:0]          hdr_n;
  logic [ADDR_BITS:0]   addr_p1;
  logic                 accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      n_q     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
`ifdef IMEM_LOADER_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    addr_d   = addr_q;
    n_d      = n_q;
`ifdef IMEM_LOADER_CSUM_EN
    sum_d    = sum_q;
`endif
    rx_ready = 1'b0;
    wr_en    = 1'b0;
    accept   = 1'b0;
    hdr_n    = {rx_data, word_q[31:8]};
    addr_p1  = {1'b0, addr_q} + {{ADDR_BITS{1'b0}}, 1'b1};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
          addr_d  = '0;
`ifdef IMEM_LOADER_CSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_HDR: begin
        rx_ready = 1'b1;
        accept   = rx_valid;
        if (accept) begin
          word_d = hdr_n;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            addr_d = '0;
            if (hdr_n == 32'd0) begin
              state_d = S_END;
            end else if ({1'b0, hdr_n} > MAX_N) begin
              state_d = S_ERR;
            end else begin
              n_d     = hdr_n[ADDR_BITS:0];
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        rx_ready = 1'b1;
        accept   = rx_valid;
        if (accept) begin
          word_d = {rx_data, word_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
          sum_d  = sum_q + rx_data;
`endif
          if (cnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en = 1'b1;
        // Address is held on the final word so it never wraps at full capacity.
        if (addr_p1 == n_q) begin
          state_d = S_END;
        end else begin
          addr_d  = addr_p1[ADDR_BITS-1:0];
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM: begin
        rx_ready = 1'b1;
        accept   = rx_valid;
        if (accept) state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_addr   = addr_q;
  assign wr_data   = word_q;
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERR);
  assign core_hold = (state_q != S_IDLE) && (state_q != S_DONE);
  assign busy      = core_hold && (state_q != S_ERR);

endmodule
